// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU/loader widths, reset PC base address and loader FSM states.
package cpu_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_BASE_ADDR = 0;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} ld_state_e;
endpackage

// File: rtl/program_loader.sv
// program_loader: streams a boot image into RAM, verifies its checksum, then releases the CPU.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  ld_state_e r_state;
  logic [ADDR_W:0] r_len, r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sum, w_sum_nx;
  logic w_xfer, w_len_ok, w_go, w_ck_ok;
  assign in_ready = r_state == LOAD || r_state == CHECK;
  assign w_xfer = in_valid && in_ready;
  assign w_len_ok = len != '0 && len <= {1'b1, {ADDR_W{1'b0}}};
  assign w_go = start && (r_state == IDLE || r_state == RUN || r_state == ERROR);
  assign w_cnt_nx = r_cnt + (ADDR_W+1)'(1);
  assign w_sum_nx = r_sum + in_data;
  assign w_ck_ok = w_sum_nx == '0;
  // A bad start while RUN is ignored so a running CPU is never dropped by a malformed request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_sum     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (w_go && w_len_ok) begin
        r_state <= LOAD;
        r_len   <= len;
        r_addr  <= ADDR_W'(BASE_ADDR);
        r_sum   <= '0;
        r_cnt   <= '0;
        cpu_rst <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b0;
      end else if (w_go && r_state != RUN) begin
        r_state <= ERROR;
        cpu_rst <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b1;
      end else if (w_xfer && r_state == LOAD) begin
        mem_we    <= 1'b1;
        mem_addr  <= r_addr;
        mem_wdata <= in_data;
        r_addr    <= r_addr + ADDR_W'(1);
        r_sum     <= w_sum_nx;
        r_cnt     <= w_cnt_nx;
        r_state   <= w_cnt_nx == r_len ? CHECK : LOAD;
      end else if (w_xfer) begin
        r_state <= w_ck_ok ? RUN : ERROR;
        cpu_rst <= !w_ck_ok;
        done    <= w_ck_ok;
        err     <= !w_ck_ok;
      end
    end
  end
endmodule
